// File: rtl/rv64_pkg.sv
// Shared RV64 widths, constants and the fetch FSM state type.
package rv64_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    // addi x0, x0, 0 -- canonical NOP used for killed / misaligned slots
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage : rv64_pkg

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: issues one imem request, waits for
// the word, holds it for decode, and honours control-flow redirects that
// may arrive at any point.
module fetch_unit
    import rv64_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic            out_misaligned
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [ILEN-1:0] out_instr_q, out_instr_d;
    logic            out_mis_q, out_mis_d;
    logic            pc_misaligned;

    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    // A redirect suppresses both the stale request and the stale hand-off in the same cycle.
    assign imem_req_valid = rst_n && (state_q == REQ) && !pc_misaligned && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign out_valid      = (state_q == HOLD) && !redirect_valid;
    assign out_pc         = out_pc_q;
    assign out_instr      = out_instr_q;
    assign out_misaligned = out_mis_q;

    // State, PC, drop flag and output slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= NOP_INSTR;
            out_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_mis_q   <= out_mis_d;
        end
    end

    // Next-state logic; redirect is tested first in every state so it wins.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_mis_d   = out_mis_q;

        unique case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (pc_misaligned) begin
                    out_pc_d    = pc_q;
                    out_instr_d = NOP_INSTR;
                    out_mis_d   = 1'b1;
                    state_d     = HOLD;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_resp_valid) begin
                        // Outstanding response retired right now; nothing left to drop.
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        out_pc_d    = pc_q;
                        out_instr_d = imem_resp_data;
                        out_mis_d   = 1'b0;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (out_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit: one vector per clock cycle.
module tb_fetch_unit;
    import rv64_pkg::*;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misaligned;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_misaligned  (out_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic        rr;
        logic        resp;
        logic [31:0] rdata;
        logic        ordy;
        logic        e_rq;
        logic [63:0] e_addr;
        logic        e_ov;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t main_q[$];
    vec_t rst_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(logic rv, logic [63:0] rpc, logic rr, logic resp,
                                logic [31:0] rdata, logic ordy, logic e_rq,
                                logic [63:0] e_addr, logic e_ov, logic [63:0] e_pc,
                                logic [31:0] e_instr, logic e_mis);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rr = rr; v.resp = resp; v.rdata = rdata;
        v.ordy = ordy; v.e_rq = e_rq; v.e_addr = e_addr; v.e_ov = e_ov;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    // Drive one vector after the rising edge, compare on the falling edge, advance one cycle.
    task automatic apply(input string tag, input int idx, input vec_t v);
        redirect_valid  = v.rv;
        redirect_pc     = v.rpc;
        imem_req_ready  = v.rr;
        imem_resp_valid = v.resp;
        imem_resp_data  = v.rdata;
        out_ready       = v.ordy;
        @(negedge clk);
        n_vec++;
        if (imem_req_valid !== v.e_rq) begin
            n_miss++;
            $display("FAIL %s[%0d] req_valid: got %b want %b", tag, idx, imem_req_valid, v.e_rq);
        end
        if (imem_req_addr !== v.e_addr) begin
            n_miss++;
            $display("FAIL %s[%0d] req_addr: got %h want %h", tag, idx, imem_req_addr, v.e_addr);
        end
        if (out_valid !== v.e_ov) begin
            n_miss++;
            $display("FAIL %s[%0d] out_valid: got %b want %b", tag, idx, out_valid, v.e_ov);
        end
        if (out_pc !== v.e_pc) begin
            n_miss++;
            $display("FAIL %s[%0d] out_pc: got %h want %h", tag, idx, out_pc, v.e_pc);
        end
        if (out_instr !== v.e_instr) begin
            n_miss++;
            $display("FAIL %s[%0d] out_instr: got %h want %h", tag, idx, out_instr, v.e_instr);
        end
        if (out_misaligned !== v.e_mis) begin
            n_miss++;
            $display("FAIL %s[%0d] out_misaligned: got %b want %b", tag, idx, out_misaligned, v.e_mis);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                rv  rpc          rr  rsp rdata         ordy rq  addr     ov  out_pc   out_instr     mis
        // REQ-034 basic fetch
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  1, 64'h1000, 0, 64'h0,    NOP,          0));
        main_q.push_back(mk(0, 64'h0,      0, 1, 32'h00500093, 0,  0, 64'h1000, 0, 64'h0,    NOP,          0));
        main_q.push_back(mk(0, 64'h0,      0, 0, 32'h0,        1,  0, 64'h1000, 1, 64'h1000, 32'h00500093, 0));
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  1, 64'h1004, 0, 64'h1000, 32'h00500093, 0));
        main_q.push_back(mk(0, 64'h0,      0, 1, 32'h00A00113, 0,  0, 64'h1004, 0, 64'h1000, 32'h00500093, 0));
        // REQ-035 back-pressure for 5 cycles, then transfer
        for (int i = 0; i < 6; i++)
            main_q.push_back(mk(0, 64'h0,  0, 0, 32'h0,        (i == 5), 0, 64'h1004, 1, 64'h1004, 32'h00A00113, 0));
        main_q.push_back(mk(0, 64'h0,      0, 0, 32'h0,        0,  1, 64'h1008, 0, 64'h1004, 32'h00A00113, 0));
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  1, 64'h1008, 0, 64'h1004, 32'h00A00113, 0));
        // REQ-036 redirect in WAIT, response 3 cycles later dropped
        main_q.push_back(mk(1, 64'h2000,   0, 0, 32'h0,        0,  0, 64'h1008, 0, 64'h1004, 32'h00A00113, 0));
        main_q.push_back(mk(0, 64'h0,      0, 0, 32'h0,        0,  0, 64'h2000, 0, 64'h1004, 32'h00A00113, 0));
        main_q.push_back(mk(0, 64'h0,      0, 0, 32'h0,        0,  0, 64'h2000, 0, 64'h1004, 32'h00A00113, 0));
        main_q.push_back(mk(0, 64'h0,      0, 1, 32'hDEADBEEF, 1,  0, 64'h2000, 0, 64'h1004, 32'h00A00113, 0));
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  1, 64'h2000, 0, 64'h1004, 32'h00A00113, 0));
        main_q.push_back(mk(0, 64'h0,      0, 1, 32'h00000033, 0,  0, 64'h2000, 0, 64'h1004, 32'h00A00113, 0));
        // REQ-037 redirect in HOLD with out_ready high
        main_q.push_back(mk(1, 64'h3000,   0, 0, 32'h0,        1,  0, 64'h2000, 0, 64'h2000, 32'h00000033, 0));
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  1, 64'h3000, 0, 64'h2000, 32'h00000033, 0));
        // Redirect coinciding with the response: straight to REQ, nothing dropped later
        main_q.push_back(mk(1, 64'h4000,   0, 1, 32'h44444444, 0,  0, 64'h3000, 0, 64'h2000, 32'h00000033, 0));
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  1, 64'h4000, 0, 64'h2000, 32'h00000033, 0));
        main_q.push_back(mk(0, 64'h0,      0, 1, 32'h11111111, 0,  0, 64'h4000, 0, 64'h2000, 32'h00000033, 0));
        main_q.push_back(mk(0, 64'h0,      0, 0, 32'h0,        1,  0, 64'h4000, 1, 64'h4000, 32'h11111111, 0));
        // REQ-038 redirect to misaligned target in REQ (request gated)
        main_q.push_back(mk(1, 64'h2002,   1, 0, 32'h0,        0,  0, 64'h4004, 0, 64'h4000, 32'h11111111, 0));
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  0, 64'h2002, 0, 64'h4000, 32'h11111111, 0));
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  0, 64'h2002, 1, 64'h2002, NOP,          1));
        // REQ-039 wrap from the top of the address space
        main_q.push_back(mk(1, TOP_PC,     0, 0, 32'h0,        1,  0, 64'h2002, 0, 64'h2002, NOP,          1));
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  1, TOP_PC,   0, 64'h2002, NOP,          1));
        main_q.push_back(mk(0, 64'h0,      0, 1, 32'h22222222, 0,  0, TOP_PC,   0, 64'h2002, NOP,          1));
        main_q.push_back(mk(0, 64'h0,      0, 0, 32'h0,        1,  0, TOP_PC,   1, TOP_PC,   32'h22222222, 0));
        main_q.push_back(mk(0, 64'h0,      0, 0, 32'h0,        0,  1, 64'h0,    0, TOP_PC,   32'h22222222, 0));
        // REQ-024 second redirect while drop pending: newest target wins
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  1, 64'h0,    0, TOP_PC,   32'h22222222, 0));
        main_q.push_back(mk(1, 64'h5000,   0, 0, 32'h0,        0,  0, 64'h0,    0, TOP_PC,   32'h22222222, 0));
        main_q.push_back(mk(1, 64'h6000,   0, 0, 32'h0,        0,  0, 64'h5000, 0, TOP_PC,   32'h22222222, 0));
        main_q.push_back(mk(0, 64'h0,      0, 1, 32'h55555555, 0,  0, 64'h6000, 0, TOP_PC,   32'h22222222, 0));
        main_q.push_back(mk(0, 64'h0,      1, 0, 32'h0,        0,  1, 64'h6000, 0, TOP_PC,   32'h22222222, 0));

        // After a reset taken mid-WAIT: clean restart, first response is kept
        rst_q.push_back(mk(0, 64'h0,       1, 0, 32'h0,        0,  1, 64'h1000, 0, 64'h0,    NOP,          0));
        rst_q.push_back(mk(0, 64'h0,       0, 1, 32'h00500093, 0,  0, 64'h1000, 0, 64'h0,    NOP,          0));
        rst_q.push_back(mk(0, 64'h0,       0, 0, 32'h0,        1,  0, 64'h1000, 1, 64'h1000, 32'h00500093, 0));
        rst_q.push_back(mk(0, 64'h0,       0, 0, 32'h0,        0,  1, 64'h1004, 0, 64'h1000, 32'h00500093, 0));

        rst_n = 1'b0;
        // Values held during reset, even with ready asserted
        for (int i = 0; i < 2; i++)
            apply("reset", i, mk(0, 64'h0, 1, 0, 32'h0, 1, 0, RST_PC, 0, 64'h0, NOP, 0));
        rst_n = 1'b1;

        foreach (main_q[i]) apply("main", i, main_q[i]);

        // DUT is now in WAIT with a request outstanding; pull reset mid-transaction.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++)
            apply("midrst", i, mk(0, 64'h0, 1, 0, 32'h0, 0, 0, RST_PC, 0, 64'h0, NOP, 0));
        rst_n = 1'b1;
        foreach (rst_q[i]) apply("after_rst", i, rst_q[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 64'h0, PC of the first fetch after reset.
REQ-002 Port: clk  input  1  sole clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: redirect_valid  input  1  taken branch/jump from control_flow (flow_change).
REQ-005 Port: redirect_pc  input  64  target PC from control_flow (next_pc).
REQ-006 Port: imem_req_valid  output  1  fetch request valid.
REQ-007 Port: imem_req_ready  input  1  memory accepts request.
REQ-008 Port: imem_req_addr  output  64  fetch address.
REQ-009 Port: imem_resp_valid  input  1  instruction word returned.
REQ-010 Port: imem_resp_data  input  32  instruction word.
REQ-011 Port: out_valid  output  1  instruction available to decode.
REQ-012 Port: out_ready  input  1  decode accepts.
REQ-013 Port: out_pc  output  64  PC of out_instr.
REQ-014 Port: out_instr  output  32  fetched instruction.
REQ-015 Port: out_misaligned  output  1  out_pc[1:0] != 0; out_instr is then 32'h00000013.

Function
REQ-016 States: REQ (drive request), WAIT (one request outstanding), HOLD (instruction registered, awaiting out_ready).
REQ-017 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_valid&&imem_req_ready -> WAIT.
REQ-018 REQ with pc[1:0]!=0: no request issued; load out_pc=pc, out_instr=32'h00000013, out_misaligned=1 -> HOLD.
REQ-019 WAIT: on imem_resp_valid, capture imem_resp_data into out_instr, out_pc=pc, out_misaligned=0 -> HOLD; responses never arrive in the cycle the request is accepted.
REQ-020 HOLD: out_valid=1; on out_valid&&out_ready, pc<=pc+4 -> REQ.
REQ-021 PC arithmetic is 64-bit modulo 2^64; pc+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
REQ-022 Redirect in REQ: pc<=redirect_pc; request for old pc not issued that cycle (imem_req_valid gated low); stay REQ.
REQ-023 Redirect in WAIT: pc<=redirect_pc, set drop flag; next response discarded, then -> REQ; a response arriving in the redirect cycle itself is discarded and FSM -> REQ directly without setting drop.
REQ-024 Redirect while drop set: pc updated to newest redirect_pc, drop stays set.
REQ-025 Redirect in HOLD: held instruction killed; out_valid gated low that cycle (no transfer even if out_ready=1); pc<=redirect_pc -> REQ.
REQ-026 Redirect has priority over every other event in the same cycle.
REQ-027 At most one outstanding memory request at any time.
REQ-028 out_pc/out_instr/out_misaligned stable while out_valid=1 and out_ready=0.

Reset
REQ-029 rst_n low: state=REQ, pc=RESET_PC, drop=0, out_instr=32'h00000013, out_pc=0, out_misaligned=0, out_valid=0, imem_req_valid=0 during reset.
REQ-030 Reset mid-WAIT: pending response after release is not marked by drop; the memory is reset by the same rst_n so no stale response arrives.
REQ-031 First request issued on the first clk edge after rst_n deasserts, at RESET_PC.

Structure
REQ-032 rv64_pkg holds fetch_state_t enum (REQ, WAIT, HOLD), XLEN=64, ILEN=32, NOP_INSTR=32'h00000013.
REQ-033 Single module, no sub-module; the FSM, PC register, and output register are all inside fetch_unit.

Verification
REQ-034 Reset release with RESET_PC=0x1000, req_ready=1, response 1 cycle later with 0x00500093, out_ready=1 -> out_pc=0x1000, out_instr=0x00500093, next request addr 0x1004.
REQ-035 out_ready=0 for 5 cycles in HOLD -> out_valid=1 and outputs unchanged throughout; no new imem request.
REQ-036 Redirect to 0x2000 in WAIT, response delayed 3 cycles -> response dropped, next request addr 0x2000, no out_valid before it.
REQ-037 Redirect to 0x3000 in HOLD with out_ready=1 -> no transfer that cycle, next request addr 0x3000.
REQ-038 Redirect to 0x2002 -> no imem request; out_valid=1, out_pc=0x2002, out_misaligned=1, out_instr=0x00000013.
REQ-039 pc=0xFFFF_FFFF_FFFF_FFFC transfer -> next request addr 0x0.
